// File: rtl/uart_rx_frame_ctrl_if.sv
// Receive-side frame handshake between uart_rx_frame_ctrl and its consumer.
// The master drives frame data and flags; the slave returns data_ready_in.
interface uart_rx_frame_ctrl_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid_out;
    logic                 data_ready_in;
    logic                 parity_err_out;
    logic                 frame_err_out;
    logic                 overrun_err_out;

    modport master (
        output data_out,
        output data_valid_out,
        output parity_err_out,
        output frame_err_out,
        output overrun_err_out,
        input  data_ready_in
    );

    modport slave (
        input  data_out,
        input  data_valid_out,
        input  parity_err_out,
        input  frame_err_out,
        input  overrun_err_out,
        output data_ready_in
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Oversampling UART receiver: start-bit validation, mid-bit sampling, parity/stop
// checking, and delivery of each frame with error flags over a valid/ready handshake.
module uart_rx_frame_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 baud_tick_in,
    input  logic                 rx_in,
    output logic                 busy_out,
    uart_rx_frame_ctrl_if.master rx_if
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = 1'(PARITY_ODD);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                 rx_meta_q;
    logic                 rx_s_q;

    logic [2:0]           state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 xor_q, xor_d;
    logic                 par_q, par_d;
    logic                 fr_q, fr_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 commit_c;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            xor_q   <= 1'b0;
            par_q   <= 1'b0;
            fr_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            xor_q   <= xor_d;
            par_q   <= par_d;
            fr_q    <= fr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        xor_d    = xor_q;
        par_d    = par_q;
        fr_d     = fr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        ovr_d    = 1'b0;
        commit_c = 1'b0;

        if (valid_q && rx_if.data_ready_in) begin
            valid_d = 1'b0;
        end

        if (baud_tick_in) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                            xor_d   = 1'b0;
                            par_d   = 1'b0;
                            fr_d    = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        xor_d   = xor_q ^ rx_s_q;
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                PARITY: begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        par_d   = xor_q ^ rx_s_q ^ PAR_ODD;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        fr_d   = fr_q | ~rx_s_q;
                        if (bit_q == STOP_LAST) begin
                            bit_d    = '0;
                            state_d  = IDLE;
                            commit_c = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A held, unaccepted frame wins; the newcomer is dropped and flagged.
        if (commit_c) begin
            if (!valid_q || rx_if.data_ready_in) begin
                data_d  = shift_q;
                perr_d  = par_q;
                ferr_d  = fr_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_if.data_out        = data_q;
    assign rx_if.data_valid_out  = valid_q;
    assign rx_if.parity_err_out  = perr_q;
    assign rx_if.frame_err_out   = ferr_q;
    assign rx_if.overrun_err_out = ovr_q;
    assign busy_out              = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: default instance (8E1) and an 8N2 instance.
module tb_uart_rx_frame_ctrl;

    logic clk;
    logic rst_a, rst_b;
    logic tick;
    logic rx_a, rx_b;
    logic busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int rises_a = 0;
    int ovr_a = 0;
    logic va_prev = 1'b0;
    int saved;

    uart_rx_frame_ctrl_if #(.DATA_BITS(8)) a_if ();
    uart_rx_frame_ctrl_if #(.DATA_BITS(8)) b_if ();

    uart_rx_frame_ctrl dut_a (
        .Clk          (clk),
        .reset_n      (rst_a),
        .baud_tick_in (tick),
        .rx_in        (rx_a),
        .busy_out     (busy_a),
        .rx_if        (a_if.master)
    );

    uart_rx_frame_ctrl #(.PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .Clk          (clk),
        .reset_n      (rst_b),
        .baud_tick_in (tick),
        .rx_in        (rx_b),
        .busy_out     (busy_b),
        .rx_if        (b_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter plus valid-edge and overrun-pulse monitor for instance A.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (a_if.data_valid_out === 1'b1 && va_prev === 1'b0) begin
            rise_cyc = cyc;
            rises_a  = rises_a + 1;
        end
        if (a_if.data_valid_out === 1'b0 && va_prev === 1'b1) fall_cyc = cyc;
        va_prev = a_if.data_valid_out;
        if (a_if.overrun_err_out === 1'b1) ovr_a = ovr_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v, input bit mark);
        @(posedge clk);
        #1;
        if (sel) rx_b = v;
        else rx_a = v;
        if (mark) start_cyc = cyc;
        repeat (15) @(posedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic pbit, input int nstop, input logic s0, input logic s1);
        logic b [0:11];
        int n;
        n = 0;
        b[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            b[n] = d[i]; n++;
        end
        if (use_par) begin
            b[n] = pbit; n++;
        end
        b[n] = s0; n++;
        if (nstop == 2) begin
            b[n] = s1; n++;
        end
        for (int k = 0; k < n; k++) drive_bit(sel, b[k], k == 0);
        #1;
        if (sel) rx_b = 1'b1;
        else rx_a = 1'b1;
    endtask

    initial begin
        tick = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_if.data_ready_in = 1'b1;
        b_if.data_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(a_if.data_valid_out), 32'd0);
        check("rst_data", 32'(a_if.data_out), 32'h00);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ovr", 32'(a_if.overrun_err_out), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (4) @(posedge clk);

        // 1: clean 0xA5, latency and one-cycle valid
        send_frame(0, 8'hA5, 1, 1'b0, 1, 1'b1, 1'b0);
        check("t1_data", 32'(a_if.data_out), 32'hA5);
        check("t1_perr", 32'(a_if.parity_err_out), 32'd0);
        check("t1_ferr", 32'(a_if.frame_err_out), 32'd0);
        check("t1_rises", 32'(rises_a), 32'd1);
        check("t1_latency", 32'(rise_cyc - start_cyc), 32'd171);
        check("t1_valid_len", 32'(fall_cyc - rise_cyc), 32'd1);
        check("t1_valid_now", 32'(a_if.data_valid_out), 32'd0);

        // 2: bad parity, then good parity
        send_frame(0, 8'h3C, 1, 1'b1, 1, 1'b1, 1'b0);
        check("t2_data", 32'(a_if.data_out), 32'h3C);
        check("t2_perr", 32'(a_if.parity_err_out), 32'd1);
        check("t2_ferr", 32'(a_if.frame_err_out), 32'd0);
        send_frame(0, 8'h01, 1, 1'b1, 1, 1'b1, 1'b0);
        check("t2b_data", 32'(a_if.data_out), 32'h01);
        check("t2b_perr", 32'(a_if.parity_err_out), 32'd0);

        // 3: short glitch aborts START
        saved = rises_a;
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_a = 1'b1;
        check("t3_busy_mid", 32'(busy_a), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("t3_busy_after", 32'(busy_a), 32'd0);
        check("t3_no_valid", 32'(rises_a - saved), 32'd0);
        send_frame(0, 8'h55, 1, 1'b0, 1, 1'b1, 1'b0);
        check("t3_data", 32'(a_if.data_out), 32'h55);
        check("t3_perr", 32'(a_if.parity_err_out), 32'd0);

        // 4: framing error then clean 0x00
        send_frame(0, 8'hFF, 1, 1'b0, 1, 1'b0, 1'b0);
        check("t4_data", 32'(a_if.data_out), 32'hFF);
        check("t4_ferr", 32'(a_if.frame_err_out), 32'd1);
        check("t4_perr", 32'(a_if.parity_err_out), 32'd0);
        send_frame(0, 8'h00, 1, 1'b0, 1, 1'b1, 1'b0);
        check("t4b_data", 32'(a_if.data_out), 32'h00);
        check("t4b_ferr", 32'(a_if.frame_err_out), 32'd0);
        check("t4b_perr", 32'(a_if.parity_err_out), 32'd0);

        // 5: overrun with consumer stalled
        a_if.data_ready_in = 1'b0;
        saved = ovr_a;
        send_frame(0, 8'h11, 1, 1'b0, 1, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1, 1'b0, 1, 1'b1, 1'b0);
        check("t5_data", 32'(a_if.data_out), 32'h11);
        check("t5_valid", 32'(a_if.data_valid_out), 32'd1);
        check("t5_ovr_pulses", 32'(ovr_a - saved), 32'd1);
        check("t5_ovr_now", 32'(a_if.overrun_err_out), 32'd0);
        a_if.data_ready_in = 1'b1;
        @(posedge clk);
        #1;
        check("t5_valid_clr", 32'(a_if.data_valid_out), 32'd0);
        check("t5_data_held", 32'(a_if.data_out), 32'h11);

        // 6: 8N2 instance, reset mid-DATA then second stop bit low
        b_if.data_ready_in = 1'b0;
        send_frame(1, 8'h33, 0, 1'b0, 2, 1'b1, 1'b1);
        check("t6_pre_valid", 32'(b_if.data_valid_out), 32'd1);
        check("t6_pre_data", 32'(b_if.data_out), 32'h33);
        drive_bit(1, 1'b0, 0);
        drive_bit(1, 1'b1, 0);
        drive_bit(1, 1'b0, 0);
        drive_bit(1, 1'b1, 0);
        #1;
        check("t6_busy_data", 32'(busy_b), 32'd1);
        rst_b = 1'b0;
        #1;
        check("t6_rst_data", 32'(b_if.data_out), 32'h00);
        check("t6_rst_valid", 32'(b_if.data_valid_out), 32'd0);
        check("t6_rst_perr", 32'(b_if.parity_err_out), 32'd0);
        check("t6_rst_ferr", 32'(b_if.frame_err_out), 32'd0);
        check("t6_rst_ovr", 32'(b_if.overrun_err_out), 32'd0);
        check("t6_rst_busy", 32'(busy_b), 32'd0);
        rx_b = 1'b1;
        @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6_idle_busy", 32'(busy_b), 32'd0);
        b_if.data_ready_in = 1'b1;
        send_frame(1, 8'h7E, 0, 1'b0, 2, 1'b1, 1'b0);
        check("t6_data", 32'(b_if.data_out), 32'h7E);
        check("t6_ferr", 32'(b_if.frame_err_out), 32'd1);
        check("t6_perr", 32'(b_if.parity_err_out), 32'd0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Parametrised UART receive controller and the next generation of the team's receiver FSM. It oversamples the serial line and validates the start bit. It samples data bits at mid-bit and checks optional parity and 1 or 2 stop bits. Each completed frame is delivered on a valid/ready handshake with per-frame parity, framing and overrun flags. It sits between the baud-rate generator, which supplies oversample ticks, and the receive-side consumer logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9, received LSB first
PARITY_EN, 1, 1 = a parity bit follows the data bits, 0 = no parity bit
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2
OVERSAMPLE, 16, baud ticks per bit, even, minimum 4

Ports:
Clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
baud_tick_in  input  1  single-cycle oversample strobe, OVERSAMPLE strobes per bit time
rx_in  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received data word
data_valid_out  output  1  data_out and the error flags hold a frame that has not been consumed
data_ready_in  input  1  consumer accepts the frame when high together with data_valid_out
parity_err_out  output  1  parity mismatch on the held frame
frame_err_out  output  1  a stop bit of the held frame was sampled low
overrun_err_out  output  1  one-cycle pulse: a completed frame was dropped
busy_out  output  1  FSM is not in IDLE

Behaviour:
- Reset: asserting reset_n low asynchronously forces IDLE. All outputs go to 0. The tick counter, bit counter and shift register clear. Both synchroniser flops are set to 1.
- Reset mid-frame: the partial frame is discarded. The held output frame is cleared.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s and are taken only on cycles where baud_tick_in=1.
- tick_cnt counts baud ticks in the range 0..OVERSAMPLE-1. bit_cnt counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: at tick_cnt = OVERSAMPLE/2-1, sample rx_s.
  - rx_s=1: glitch; return to IDLE and flag nothing.
  - rx_s=0: go to DATA with tick_cnt=0 and bit_cnt=0. All later samples land at mid-bit.
- DATA: at tick_cnt = OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first reception) and update the running XOR. After DATA_BITS samples, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: at tick_cnt = OVERSAMPLE-1, sample the parity bit. par_err = (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0. Go to STOP.
- STOP: at tick_cnt = OVERSAMPLE-1, sample each stop bit. Any low sample sets fr_err. The FSM does not wait for rx_s to return high.
  - After the final stop sample, go to IDLE and perform the frame commit.
  - A start edge beginning half a bit later is detected normally.
- Frame commit happens on the cycle after the tick that samples the final stop bit. That tick plus one Clk cycle is the latency from mid-stop to data_valid_out.
  - If data_valid_out=0, or data_valid_out=1 and data_ready_in=1 in the same cycle: load data_out, parity_err_out and frame_err_out, and set data_valid_out=1.
  - If data_valid_out=1 and data_ready_in=0: keep the held frame unchanged, drop the new frame, and pulse overrun_err_out for 1 cycle.
- Handshake: when data_valid_out=1 and data_ready_in=1 with no commit in that cycle, data_valid_out clears on the next edge. data_out and the error flags hold their values until the next commit.
- parity_err_out is always 0 when PARITY_EN=0.
- busy_out=1 in START, DATA, PARITY and STOP.
- baud_tick_in low for a long time freezes the FSM with no timeout.

Test Plan:
Common setup for all cases: defaults (8 data bits, even parity, 1 stop bit, OVERSAMPLE=16), baud_tick_in=1 every cycle, data_ready_in=1 unless stated.
1. Send 0xA5 with parity 0 and stop 1 -> data_out=0xA5, data_valid_out high for 1 cycle, parity_err_out=0, frame_err_out=0, valid rises 1 cycle after the mid-stop tick.
2. Send 0x3C with the parity bit forced to 1 -> data_out=0x3C, parity_err_out=1, frame_err_out=0. Then send 0x01 with parity 1 (correct for even parity) -> parity_err_out=0.
3. rx_in low for 5 ticks, then high -> START is aborted, busy_out returns to 0 with no valid. A following 0x55 frame is received correctly.
4. Send 0xFF with the stop bit low -> frame_err_out=1 and data_out=0xFF. The next frame 0x00 is received cleanly with both error flags 0.
5. Hold data_ready_in=0 and send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overrun_err_out pulses once. Raise data_ready_in -> valid clears.
6. Set STOP_BITS=2 and PARITY_EN=0, then assert reset_n low mid-DATA and release -> all outputs are 0 and the state is IDLE. A following 0x7E frame with its second stop bit low gives frame_err_out=1.
